// File: rtl/coin_accumulator_pkg.sv
// Shared types and constants for the coin accumulator datapath:
// counter width and thresholds, the counter/segment types and the
// active-low 7-segment hex table {g,f,e,d,c,b,a}.
package coin_pkg;

    localparam int CNT_W         = 4;
    localparam int LIMIT         = 10;
    localparam int COIN_HI_VALUE = 5;

    typedef logic [CNT_W-1:0] coin_cnt_t;
    typedef logic [6:0]       seg7_t;

    localparam seg7_t SEG7_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin accumulator bus: raw coin sensor levels and clear in,
// running total, limit flag and display out.
interface coin_accumulator_if;
    import coin_pkg::*;

    logic      coin_100;
    logic      coin_500;
    logic      clear;
    coin_cnt_t total_coins;
    logic      coins_limit;
    seg7_t     total_coins_display;

    modport master (
        output coin_100, coin_500, clear,
        input  total_coins, coins_limit, total_coins_display
    );

    modport slave (
        input  coin_100, coin_500, clear,
        output total_coins, coins_limit, total_coins_display
    );

endinterface

// File: rtl/coin_seg7_decoder.sv
// Combinational hex digit to active-low 7-segment decoder; shared with
// the change display.
module coin_seg7_decoder
    import coin_pkg::*;
(
    input  logic [3:0] digit,
    output seg7_t      seg
);

    // Table lookup of the segment pattern for the digit
    always_comb begin
        seg = SEG7_HEX[digit];
    end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: synchronises the two coin sensors, detects rising
// edges, keeps a saturating total in 100-unit steps, flags the purchase
// limit and drives the 7-segment display of the total.
// Optional build macro COIN_AUTO_CLEAR_EN: total clears itself the cycle
// after the limit is reached, making coins_limit a one-cycle pulse.
module coin_accumulator #(
    parameter int CNT_W         = coin_pkg::CNT_W,
    parameter int LIMIT         = coin_pkg::LIMIT,
    parameter int COIN_HI_VALUE = coin_pkg::COIN_HI_VALUE
) (
    input  logic               clock,
    input  logic               reset,
    coin_accumulator_if.slave  bus
);
    import coin_pkg::*;

    localparam int                 SUM_W   = CNT_W + 3;
    localparam logic [SUM_W-1:0]   SUM_MAX = SUM_W'({CNT_W{1'b1}});
    localparam logic [SUM_W-1:0]   HI_STEP = SUM_W'(COIN_HI_VALUE);
    localparam logic [CNT_W-1:0]   LIMIT_V = CNT_W'(LIMIT);

    logic             c100_s1_r, c100_s2_r, c100_p_r;
    logic             c500_s1_r, c500_s2_r, c500_p_r;
    logic [CNT_W-1:0] total_r;

    logic             ev100_s, ev500_s;
    logic             limit_s;
    logic             clear_eff_s;
    logic [SUM_W-1:0] sum_s;
    logic [CNT_W-1:0] total_next_s;
    seg7_t            seg_s;

    // Rising-edge events from the synchronised coin levels
    always_comb begin
        ev100_s = c100_s2_r & ~c100_p_r;
        ev500_s = c500_s2_r & ~c500_p_r;
    end

    // Limit compare and effective clear (optionally self-clearing at limit)
    always_comb begin
        limit_s = (total_r >= LIMIT_V);
`ifdef COIN_AUTO_CLEAR_EN
        clear_eff_s = bus.clear | limit_s;
`else
        clear_eff_s = bus.clear;
`endif
    end

    // Wide sum of this cycle's coin steps, saturated to the counter range
    always_comb begin
        sum_s = SUM_W'(total_r);
        if (ev100_s) begin
            sum_s = sum_s + SUM_W'(1'b1);
        end else begin
            sum_s = sum_s;
        end
        if (ev500_s) begin
            sum_s = sum_s + HI_STEP;
        end else begin
            sum_s = sum_s;
        end
        if (clear_eff_s) begin
            total_next_s = {CNT_W{1'b0}};
        end else if (sum_s > SUM_MAX) begin
            total_next_s = {CNT_W{1'b1}};
        end else begin
            total_next_s = sum_s[CNT_W-1:0];
        end
    end

    // Synchronisers, edge registers and running total
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c100_s1_r <= 1'b0;
            c100_s2_r <= 1'b0;
            c100_p_r  <= 1'b0;
            c500_s1_r <= 1'b0;
            c500_s2_r <= 1'b0;
            c500_p_r  <= 1'b0;
            total_r   <= {CNT_W{1'b0}};
        end else begin
            c100_s1_r <= bus.coin_100;
            c100_s2_r <= c100_s1_r;
            c100_p_r  <= c100_s2_r;
            c500_s1_r <= bus.coin_500;
            c500_s2_r <= c500_s1_r;
            c500_p_r  <= c500_s2_r;
            total_r   <= total_next_s;
        end
    end

    coin_seg7_decoder u_seg7 (
        .digit (4'(total_r)),
        .seg   (seg_s)
    );

    // Drive the bus outputs from the total and its derived views
    always_comb begin
        bus.total_coins         = coin_cnt_t'(total_r);
        bus.coins_limit         = limit_s;
        bus.total_coins_display = seg_s;
    end

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed vector table,
// hand-written multi-cycle corner sequences and a randomized run
// compared against a behavioural model.
module tb_coin_accumulator;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    coin_accumulator_if bus();

    coin_accumulator dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Independent copy of the expected segment patterns
    localparam logic [6:0] EXP_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        bit         c100;
        bit         c500;
        bit         clr;
        int         total;
        bit         limit;
        logic [6:0] disp;
    } vec_t;

    // Behavioural model: total plus history of sampled input levels
    // (front = most recent sample).
    int m_total;
    bit h100[$];
    bit h500[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_total = 0;
        h100 = '{1'b0, 1'b0, 1'b0};
        h500 = '{1'b0, 1'b0, 1'b0};
    endtask

    // A coin counts at the edge two clocks after its first high sample
    task automatic model_edge(input bit a, input bit b, input bit c);
        bit e1, e5, auto_clr;
        int s;
        e1 = h100[1] & ~h100[2];
        e5 = h500[1] & ~h500[2];
`ifdef COIN_AUTO_CLEAR_EN
        auto_clr = (m_total >= 10);
`else
        auto_clr = 1'b0;
`endif
        if (c || auto_clr) begin
            m_total = 0;
        end else begin
            s = m_total + (e1 ? 1 : 0) + (e5 ? 5 : 0);
            m_total = (s > 15) ? 15 : s;
        end
        h100.push_front(a);
        h500.push_front(b);
        void'(h100.pop_back());
        void'(h500.pop_back());
    endtask

    task automatic step(input bit a, input bit b, input bit c);
        @(negedge clock);
        bus.coin_100 = a;
        bus.coin_500 = b;
        bus.clear    = c;
        @(posedge clock);
        if (!reset) model_reset();
        else model_edge(a, b, c);
        #1;
    endtask

    task automatic pulse(input bit a, input bit b);
        for (int i = 0; i < 4; i++) step(a, b, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_exp(input string name, input int t, input bit l, input logic [6:0] d);
        check({name, "_total"}, int'(bus.total_coins), t);
        check({name, "_limit"}, int'(bus.coins_limit), int'(l));
        check({name, "_disp"}, int'(bus.total_coins_display), int'(d));
    endtask

    task automatic check_model(input string name);
        check_exp(name, m_total, (m_total >= 10), EXP_SEG[m_total]);
    endtask

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit r100, r500;
        bus.coin_100 = 1'b0;
        bus.coin_500 = 1'b0;
        bus.clear    = 1'b0;
        model_reset();

        // Reset held: coin activity must not leak through
        for (int i = 0; i < 6; i++) begin
            step(i[0], i[1], 1'b0);
            check_exp("in_reset", 0, 1'b0, 7'b1000000);
        end
        @(negedge clock);
        bus.coin_100 = 1'b0;
        bus.coin_500 = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check_exp("post_reset", 0, 1'b0, 7'b1000000);

`ifndef COIN_AUTO_CLEAR_EN
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 7'b1111001};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2,  1'b0, 7'b0100100};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3,  1'b0, 7'b0110000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8,  1'b0, 7'b0000000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 9,  1'b0, 7'b0010000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 10, 1'b1, 7'b0001000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 11, 1'b1, 7'b0000011};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 15, 1'b1, 7'b0001110};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 0,  1'b0, 7'b1000000};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 6,  1'b0, 7'b0000010};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 11, 1'b1, 7'b0000011};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 15, 1'b1, 7'b0001110};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 0,  1'b0, 7'b1000000};
        for (int i = 0; i < 13; i++) begin
            pulse(tbl[i].c100, tbl[i].c500);
            if (tbl[i].clr) step(1'b0, 1'b0, 1'b1);
            check_exp($sformatf("vec%0d", i), tbl[i].total, tbl[i].limit, tbl[i].disp);
        end
`endif

        // Latency: first high sample at edge 1, count at edge 3, once
        step(1'b1, 1'b0, 1'b0);
        check_exp("lat_e1", 0, 1'b0, 7'b1000000);
        step(1'b1, 1'b0, 1'b0);
        check_exp("lat_e2", 0, 1'b0, 7'b1000000);
        step(1'b1, 1'b0, 1'b0);
        check_exp("lat_e3", 1, 1'b0, 7'b1111001);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_exp("held_once", 1, 1'b0, 7'b1111001);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Clear beats a same-cycle coin event, which is dropped
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        check_exp("pre_clear", 4, 1'b0, 7'b0011001);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_exp("clear_prio", 0, 1'b0, 7'b1000000);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_exp("coin_dropped", 0, 1'b0, 7'b1000000);

        // Reset while a coin sits in the synchroniser
        step(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        check_exp("mid_reset", 0, 1'b0, 7'b1000000);
        bus.coin_100 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check_exp("reset_drop", 0, 1'b0, 7'b1000000);

`ifdef COIN_AUTO_CLEAR_EN
        // Auto clear: limit is a single-cycle pulse, then total returns to 0
        for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0);
        check_exp("auto_pre", 9, 1'b0, 7'b0010000);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_exp("auto_hit", 10, 1'b1, 7'b0001000);
        step(1'b1, 1'b0, 1'b0);
        check_exp("auto_clr", 0, 1'b0, 7'b1000000);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_exp("auto_hold", 0, 1'b0, 7'b1000000);
`endif

        // Randomized run against the model
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        r100 = 1'b0;
        r500 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r100 = ~r100;
            if ($urandom_range(0, 5) == 0) r500 = ~r500;
            step(r100, r500, ($urandom_range(0, 29) == 0));
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
